// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction fetch sequencer sitting between the PC logic and a registered
// (1-cycle read latency) instruction memory. Issues word-aligned reads, keeps
// at most one read in flight, buffers returned words with their PCs in a small
// circular fetch queue and presents the queue head to decode over valid/ready.
// Redirects flush the queue and squash the in-flight read. Fetching stops once
// an EBREAK word has been pushed, until the next redirect.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   FQ_DEPTH  fetch queue entries (power of two, >= 2)
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   mem_req         read request to instruction memory this cycle
//   mem_addr        byte address of the request (always word aligned)
//   mem_rdata       read data, valid the cycle after mem_req
//   out_valid       queue head holds a valid instruction
//   out_instr       instruction at queue head
//   out_pc          PC of instruction at queue head
//   out_ready       decode accepts the head this cycle
//   redirect_valid  branch/jump redirect request
//   redirect_pc     redirect target (bits [1:0] ignored)
//   halted          EBREAK fetched, no further requests
//
// Build option:
//   FETCH_TRACE_EN  when defined, prints every accepted instruction and every
//                   redirect. Functional behaviour is identical either way.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int              PTR_W   = $clog2(FQ_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(FQ_DEPTH);
  localparam logic [31:0]     EBREAK  = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_infl_pc;
  logic               r_inflight;
  logic               r_halted;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [31:0]        r_q_instr [FQ_DEPTH];
  logic [31:0]        r_q_pc    [FQ_DEPTH];

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic               w_ebreak;
  logic [CNT_W:0]     w_occ;

  assign w_pop = out_valid & out_ready;

  // Occupancy the queue will see once the in-flight word lands and this
  // cycle's pop retires; a new request only goes out if it still fits.
  always_comb begin
    w_occ = {1'b0, r_count}
          + {{CNT_W{1'b0}}, r_inflight}
          - {{CNT_W{1'b0}}, w_pop};
  end

  assign w_issue  = (r_state == S_RUN) && !redirect_valid && (w_occ < DEPTH_V);
  // A redirect squashes the word returning this cycle.
  assign w_push   = r_inflight && !redirect_valid;
  assign w_ebreak = w_push && (mem_rdata == EBREAK);

  assign mem_req   = w_issue;
  assign mem_addr  = r_fetch_pc;
  assign out_valid = (r_count != '0);
  assign out_instr = r_q_instr[r_head];
  assign out_pc    = r_q_pc[r_head];
  assign halted    = r_halted;

  // Control state: FSM, fetch PC, in-flight tracking, queue pointers/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_infl_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          // Redirects are ignored here; nothing is fetched yet.
          r_state <= S_RUN;
        end
        default: begin
          if (redirect_valid) begin
            r_state    <= S_RUN;
            r_halted   <= 1'b0;
            r_fetch_pc <= redirect_pc & ~32'h3;
            r_inflight <= 1'b0;
            r_count    <= '0;
            // Tail snaps to head so out_instr/out_pc keep showing the
            // last head while the queue is empty.
            r_tail     <= r_head;
          end else begin
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + CNT_W'(1);
              2'b01:   r_count <= r_count - CNT_W'(1);
              default: r_count <= r_count;
            endcase
            // A request issued alongside the EBREAK push is squashed.
            r_inflight <= w_issue & ~w_ebreak;
            if (w_issue) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
              r_infl_pc  <= r_fetch_pc;
            end
            if (w_ebreak) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Queue storage: data only, validity is carried by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_tail] <= mem_rdata;
      r_q_pc[r_tail]    <= r_infl_pc;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_pop)
        $display("Instruction Fetch: PC = %0d, Instruction = %h", out_pc, out_instr);
      if (redirect_valid && (r_state != S_BOOT))
        $display("Fetch redirect -> %h", redirect_pc & ~32'h3);
    end
  end
`else
  // Default build: no trace output.
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Bench for imem_fetch_ctrl. A registered memory model returns word n = n
// (optionally an EBREAK at one chosen address). A stream-level reference
// model tracks the program-order PC decode should see next, applying redirects
// and EBREAK halting, and checks every accepted instruction against it.
// Directed sequences cover reset timing, back-pressure, redirect squashing,
// EBREAK halt/resume, mid-stream reset and PC wrap; a random phase follows.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  imem_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents
  logic        ebreak_en;
  logic [31:0] ebreak_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ebreak_en && (a == ebreak_addr)) return EBREAK;
    return {2'b00, a[31:2]};
  endfunction

  // Registered memory: data for a request appears the following cycle.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  end

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Stream-level reference model state
  logic [31:0] exp_pc;
  logic        m_stop;
  logic        m_boot;
  logic [31:0] m_last_pc;
  int          n_req;
  int          n_pop;
  int          n_deliv;

  task automatic monitor();
    if (rst) begin
      exp_pc = RESET_PC;
      m_stop = 1'b0;
      m_boot = 1'b1;
      n_req  = 0;
      n_pop  = 0;
    end else begin
      if (mem_req) begin
        n_req++;
        check_eq("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      end
      if (halted) check_eq("halt_noreq", 32'(mem_req), 32'd0);
      if (out_valid && out_ready) begin
        check_eq("pc", out_pc, exp_pc);
        check_eq("instr", out_instr, mem_word(exp_pc));
        check_eq("post_ebreak", 32'(m_stop), 32'd0);
        m_stop    = (mem_word(exp_pc) == EBREAK);
        m_last_pc = exp_pc;
        exp_pc    = exp_pc + 32'd4;
        n_pop++;
        n_deliv++;
      end
      // Redirect wins over everything except during the boot cycle.
      if (redirect_valid && !m_boot) begin
        exp_pc = redirect_pc & ~32'h3;
        m_stop = 1'b0;
      end
      m_boot = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, observe mid-cycle.
  task automatic step(input logic r, input logic rdy, input logic rv,
                      input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    monitor();
  endtask

  // Leaves the bench observing cycle 0 (the boot cycle).
  task automatic do_reset(input logic rdy, input logic rv, input logic [31:0] rpc);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, rdy, rv, rpc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_deliv  = 0;
    m_last_pc = 32'd0;
    exp_pc   = RESET_PC;
    m_stop   = 1'b0;
    m_boot   = 1'b1;
    n_req    = 0;
    n_pop    = 0;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    ebreak_en      = 1'b0;
    ebreak_addr    = 32'd0;

    // Reset values and first-fetch timing
    do_reset(1'b1, 1'b0, 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_addr", mem_addr, RESET_PC);
    check_eq("rst_halted", 32'(halted), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("c1_req", 32'(mem_req), 32'd1);
    check_eq("c1_addr", mem_addr, RESET_PC);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("c2_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("c3_valid", 32'(out_valid), 32'd1);
    check_eq("c3_pc", out_pc, 32'd0);
    check_eq("c3_instr", out_instr, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_pc", out_pc, 32'(4 * k));
      check_eq("stream_instr", out_instr, 32'(k));
    end

    // Back-pressure: queue fills to FQ_DEPTH, requests stop, nothing lost
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("stall_req", 32'(mem_req), 32'd0);
    check_eq("stall_valid", 32'(out_valid), 32'd1);
    check_eq("buffered", 32'(n_req - n_pop), 32'(FQ_DEPTH));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("release_valid", 32'(out_valid), 32'd1);
    end

    // Redirect with a read in flight and the queue at capacity
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("pre_redir_req", 32'(mem_req), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    check_eq("redir_noreq", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("redir_req", 32'(mem_req), 32'd1);
    check_eq("redir_addr", mem_addr, 32'h0000_0040);
    check_eq("redir_flush1", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("redir_flush2", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("redir_valid", 32'(out_valid), 32'd1);
    check_eq("redir_pc", out_pc, 32'h0000_0040);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'd0);

    // EBREAK at word 3: halt, drain, resume on redirect
    ebreak_en   = 1'b1;
    ebreak_addr = 32'h0000_000C;
    do_reset(1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 20 && !halted; k++) step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("halt_seen", 32'(halted), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("halt_req", 32'(mem_req), 32'd0);
    end
    check_eq("halt_last_pc", m_last_pc, 32'h0000_000C);
    check_eq("halt_drained", 32'(out_valid), 32'd0);
    check_eq("halt_hold", 32'(halted), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("resume_halted", 32'(halted), 32'd0);
    check_eq("resume_req", 32'(mem_req), 32'd1);
    check_eq("resume_addr", mem_addr, 32'h0000_0020);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);

    // Reset mid-stream with a read in flight
    ebreak_en = 1'b0;
    check_eq("mid_pre_req", 32'(mem_req), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_req", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("refetch_req", 32'(mem_req), 32'd1);
    check_eq("refetch_addr", mem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);

    // Redirect during BOOT is ignored
    do_reset(1'b1, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("boot_redir_addr", mem_addr, RESET_PC);
    check_eq("boot_redir_req", 32'(mem_req), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);

    // Fetch PC wrap at the top of the address space
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_req0", 32'(mem_req), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("wrap_addr1", mem_addr, 32'h0000_0000);
    check_eq("wrap_req1", 32'(mem_req), 32'd1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'd0);

    // Random traffic: back-pressure, redirects, EBREAKs, occasional reset
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        r, rdy, rv;
      logic [31:0] rpc;
      r = ($urandom_range(0, 299) == 0);
      if (r) begin
        ebreak_en   = 1'($urandom_range(0, 1));
        ebreak_addr = 32'($urandom_range(0, 127)) << 2;
      end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = !r && ($urandom_range(0, 19) == 0);
      rpc = 32'($urandom_range(0, 511));
      step(r, rdy, rv, rpc);
    end
    check_eq("progress", 32'(n_deliv >= 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch sequencer between the core's program counter logic and a registered (1-cycle read latency) instruction memory. Issues word-aligned fetch requests, tracks in-flight reads, buffers returned instructions with their PCs in a small fetch queue, and hands them to decode over a valid/ready handshake. Handles taken-branch/jump redirects by flushing and squashing, and stops fetching after an EBREAK.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- FQ_DEPTH, 2, fetch queue entries (power of two, ≥2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_req  output  1  read request to instruction memory this cycle
- mem_addr  output  32  byte address of request, always [1:0]=0
- mem_rdata  input  32  read data, valid the cycle after mem_req
- out_valid  output  1  queue head holds a valid instruction
- out_instr  output  32  instruction at queue head
- out_pc  output  32  PC of instruction at queue head
- out_ready  input  1  decode accepts head this cycle
- redirect_valid  input  1  branch/jump redirect request
- redirect_pc  input  32  redirect target; bits [1:0] ignored
- halted  output  1  EBREAK fetched, no further requests

## Operation
- States: BOOT, RUN, HALTED.
- BOOT: entered on rst; lasts exactly one cycle, then RUN. No requests.
- RUN: issue when (count + inflight − pop) < FQ_DEPTH and no redirect this cycle; pop = out_valid & out_ready. On issue: mem_req=1, mem_addr=fetch_pc, fetch_pc += 4 (wraps mod 2^32), inflight set.
- Response: cycle after issue, mem_rdata pushed with its PC unless squashed. At most one in flight.
- Push of 32'h00100073 (EBREAK): entry enqueued normally; state → HALTED, halted=1. Requests issued in that same cycle are squashed.
- HALTED: no requests; queue drains normally.
- Redirect (any state except BOOT, highest priority): queue flushed, in-flight response squashed, fetch_pc ← {redirect_pc[31:2],2'b00}, halted cleared, state → RUN. No request in the redirect cycle. Pop in the same cycle is still honoured by decode but the entry is discarded by flush.
- Queue: circular FIFO, head/tail pointers wrap at FQ_DEPTH; overflow impossible by issue rule; simultaneous push and pop allowed at any occupancy.
- out_instr/out_pc undefined-but-stable (hold last head) when out_valid=0.

## Timing
- Reset values: state=BOOT, fetch_pc=RESET_PC, count=0, inflight=0, mem_req=0, mem_addr=RESET_PC, out_valid=0, halted=0.
- rst released before edge E0: BOOT in cycle 0, first mem_req in cycle 1 (addr RESET_PC), rdata in cycle 2, out_valid=1 in cycle 3.
- Issue-to-out_valid latency: 2 cycles. Redirect-to-first-request: 1 cycle; redirect-to-out_valid: 3 cycles.
- Steady state with out_ready=1: one instruction per cycle.
- rst mid-operation: all state returns to reset values next edge; in-flight response discarded.
- redirect_valid during BOOT ignored.

## Configuration
- FETCH_TRACE_EN: when defined, every accepted handshake (out_valid & out_ready) prints "Instruction Fetch: PC = <dec>, Instruction = <hex>" via $display, plus "Fetch redirect -> <hex>" on redirect. When undefined, no display statements compiled; functional behaviour identical.

## Test plan
- Reset, RESET_PC=0, memory word n = n, out_ready=1 → out_valid first in cycle 3; out_pc 0,4,8,… with out_instr 0,1,2,… one per cycle.
- out_ready=0 for 10 cycles → exactly FQ_DEPTH entries buffered, mem_req=0 afterward, no data lost; release → PCs continue consecutively.
- Redirect to 32'h00000043 while one request in flight and queue full → next mem_addr=0x40, stale data never appears, first out_pc=0x40.
- EBREAK at word 3 → halted=1 after it is pushed, last out_pc=0x0C, mem_req stays 0; redirect to 0x20 → halted=0, fetch resumes at 0x20.
- rst asserted mid-stream with request in flight → next cycle out_valid=0, mem_req=0; refetch starts at RESET_PC.
- fetch_pc=0xFFFFFFFC issue → next mem_addr=0x00000000.
